uop_queue_n: RTL

Parametrised multi-lane micro-op queue between the decoder and the issue stage. The decoder writes up to LANES uops per instruction, one per lane. The block stores each lane in internal circular storage and emits one uop per cycle in lane order (0,1,2,…) until a uop with its end-of-instruction bit set, then restarts at lane 0. Over the fixed 4-lane version it adds:
- generic width, depth and lane count
- an explicit valid output
- an almost-full flag
- a wait state for partially written instructions
- lane-overrun error detection
- a lane-0 occupancy count

---
 rtl/uop_queue_n.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/uop_queue_n.sv
// uop_queue_n: multi-lane micro-op queue between decode and issue.
//
// The decoder writes up to LANES uops per instruction, one per lane, into per-lane
// circular buffers. The queue emits one uop per non-stalled cycle in lane order
// 0,1,2,... until a uop with its end-of-instruction bit set, then restarts at lane 0.
//
// Ports:
//   CLK         clock, rising edge
//   RST         synchronous active-high reset (also clears err)
//   flush       synchronous queue clear, err retained
//   IN_uop      packed uops, lane i at [i*W +: W]
//   WR_EN       per-lane write request
//   pipe_stall  downstream cannot accept the head uop this cycle
//   OUT_uop     head uop of the current lane, NOP when not valid
//   OUT_valid   OUT_uop is a real uop
//   Q_full      some lane holds DEPTH entries
//   Q_afull     some lane count >= DEPTH-AF_MARGIN
//   err         sticky: an instruction ran past the last lane without an EOI
//   occ0        lane-0 occupancy (number of queued instructions)

module uop_queue_n #(
   parameter int unsigned W         = 39,
   parameter int unsigned LANES     = 4,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned EOI_BIT   = 27,
   parameter int unsigned AF_MARGIN = 2,
   parameter logic [W-1:0] NOP      = 39'h00_0800_0000
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         flush,
   input  logic [LANES*W-1:0]           IN_uop,
   input  logic [LANES-1:0]             WR_EN,
   input  logic                         pipe_stall,
   output logic [W-1:0]                 OUT_uop,
   output logic                         OUT_valid,
   output logic                         Q_full,
   output logic                         Q_afull,
   output logic                         err,
   output logic [$clog2(DEPTH+1)-1:0]   occ0
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned LW = $clog2(LANES);

   localparam logic [CW-1:0] DepthC   = CW'(DEPTH);
   localparam logic [CW-1:0] AfLevel  = CW'(DEPTH - AF_MARGIN);
   localparam logic [LW-1:0] LastLane = LW'(LANES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_EMIT,
      S_WAIT
   } state_e;

   logic [W-1:0]  mem_q    [LANES][DEPTH];
   logic [PW-1:0] rd_ptr_q [LANES];
   logic [PW-1:0] rd_ptr_d [LANES];
   logic [PW-1:0] wr_ptr_q [LANES];
   logic [PW-1:0] wr_ptr_d [LANES];
   logic [CW-1:0] cnt_q    [LANES];
   logic [CW-1:0] cnt_d    [LANES];

   logic [LW-1:0] cur_q, cur_d;
   state_e        state_q, state_d;
   logic          err_q, err_d;

   logic             clr;
   logic             full, afull;
   logic             pop;
   logic             any_d;
   logic [LANES-1:0] push;
   logic [LANES-1:0] pop_lane;
   logic [W-1:0]     head;

   assign clr  = RST | flush;
   assign head = mem_q[cur_q][rd_ptr_q[cur_q]];

   // Flags come from registered counts only, so a same-cycle pop never frees a slot
   // for a write; all lanes are blocked together to keep instructions whole.
   always_comb begin
      full  = 1'b0;
      afull = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         if (cnt_q[i] == DepthC)  full  = 1'b1;
         if (cnt_q[i] >= AfLevel) afull = 1'b1;
      end
   end

   // S_EMIT always implies lane cur is non-empty, so no occupancy check is needed here.
   assign pop = (state_q == S_EMIT) & ~pipe_stall & ~clr;

   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         push[i]     = WR_EN[i] & ~full & ~clr;
         pop_lane[i] = pop & (cur_q == LW'(i));
         wr_ptr_d[i] = wr_ptr_q[i] + PW'(push[i]);
         rd_ptr_d[i] = rd_ptr_q[i] + PW'(pop_lane[i]);
         cnt_d[i]    = cnt_q[i] + CW'(push[i]) - CW'(pop_lane[i]);
         if (clr) begin
            wr_ptr_d[i] = '0;
            rd_ptr_d[i] = '0;
            cnt_d[i]    = '0;
         end
      end
   end

   // Transitions look at next-cycle counts, so a uop written at one edge is shown
   // in the following cycle.
   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      err_d   = err_q;
      any_d   = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         if (cnt_d[i] != '0) any_d = 1'b1;
      end

      unique case (state_q)
         S_IDLE: begin
            if (cnt_d[0] != '0) state_d = S_EMIT;
         end
         S_EMIT: begin
            if (pop) begin
               if (head[EOI_BIT]) begin
                  cur_d = '0;
               end else if (cur_q == LastLane) begin
                  // Ran off the last lane without an EOI: resync at lane 0.
                  cur_d = '0;
                  err_d = 1'b1;
               end else begin
                  cur_d = cur_q + 1'b1;
               end

               if (cnt_d[cur_d] != '0) begin
                  state_d = S_EMIT;
               end else if ((cur_d == '0) && !any_d) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (cnt_d[cur_q] != '0) state_d = S_EMIT;
         end
         default: state_d = S_IDLE;
      endcase

      if (clr) begin
         state_d = S_IDLE;
         cur_d   = '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         cur_q   <= '0;
         err_q   <= 1'b0;
         for (int i = 0; i < LANES; i++) begin
            rd_ptr_q[i] <= '0;
            wr_ptr_q[i] <= '0;
            cnt_q[i]    <= '0;
         end
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         err_q   <= err_d;
         for (int i = 0; i < LANES; i++) begin
            rd_ptr_q[i] <= rd_ptr_d[i];
            wr_ptr_q[i] <= wr_ptr_d[i];
            cnt_q[i]    <= cnt_d[i];
         end
      end
   end

   // Storage needs no reset; only entries between rd_ptr and wr_ptr are ever shown.
   always_ff @(posedge CLK) begin
      for (int i = 0; i < LANES; i++) begin
         if (push[i]) mem_q[i][wr_ptr_q[i]] <= IN_uop[i*W +: W];
      end
   end

   assign OUT_valid = (state_q == S_EMIT);
   assign OUT_uop   = OUT_valid ? head : NOP;
   assign Q_full    = full;
   assign Q_afull   = afull;
   assign err       = err_q;
   assign occ0      = cnt_q[0];

endmodule
